// File: rtl/aes_key_schedule_otf_multi_if.sv
// Streaming interface of the on-the-fly AES key schedule: key load and round-key word output.
// The slave modport is the schedule's view and the master modport is the key source/consumer's view.
interface aes_key_schedule_otf_multi_if;
   logic         start;
   logic [1:0]   key_len;
   logic [255:0] key;
   logic         rk_ready;
   logic         rk_valid;
   logic [31:0]  rk_word;
   logic [5:0]   rk_idx;
   logic [3:0]   rk_round;
   logic         rk_last;
   logic         busy;
   logic         key_err;

   modport master (
      output start, key_len, key, rk_ready,
      input  rk_valid, rk_word, rk_idx, rk_round, rk_last, busy, key_err
   );

   modport slave (
      input  start, key_len, key, rk_ready,
      output rk_valid, rk_word, rk_idx, rk_round, rk_last, busy, key_err
   );
endinterface

// File: rtl/aes_key_schedule_otf_multi.sv
// On-the-fly AES-128/192/256 key schedule, one 32-bit round-key word per valid/ready transfer.
// Keeps only the words w[idx .. idx+Nk-1]; the word w[idx+Nk] is built while w[idx] is handed out.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] xx;
      p  = 8'h00;
      xx = x;
      for (int k = 0; k < 8; k++) begin
         if (y[k]) p = p ^ xx;
         xx = xtime(xx);
      end
      return p;
   endfunction

   logic [7:0] inv;

   // Multiplicative inverse as a^254 (0 maps to 0), then the standard affine transform.
   always_comb begin
      logic [7:0] sq;
      sq  = a;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
   end

   assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_key_schedule_otf_multi #(
   parameter bit SUPPORT_192 = 1'b1,
   parameter bit SUPPORT_256 = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   aes_key_schedule_otf_multi_if.slave   bus
);
   localparam int WIN_W = SUPPORT_256 ? 8 : (SUPPORT_192 ? 6 : 4);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state, state_n;
   logic [31:0] win   [WIN_W];
   logic [31:0] win_n [WIN_W];
   logic [2:0]  nk_m1, cnt, nk_m1_new;
   logic [5:0]  idx, last_idx, last_new;
   logic [7:0]  rcon;
   logic        key_err;
   logic        legal, xfer, rk_last, rk_valid, busy;
   logic        rot, sub_only;
   logic [31:0] temp_src, sb_in, sb_out, temp, gen_word;

   always_comb begin
      legal     = 1'b0;
      nk_m1_new = 3'd3;
      last_new  = 6'd43;
      case (bus.key_len)
         2'b00: legal = 1'b1;
         2'b01: begin legal = SUPPORT_192; nk_m1_new = 3'd5; last_new = 6'd51; end
         2'b10: begin legal = SUPPORT_256; nk_m1_new = 3'd7; last_new = 6'd59; end
         default: legal = 1'b0;
      endcase
   end

   assign rk_last = (idx == last_idx);
   assign xfer    = rk_valid & bus.rk_ready;

   // Newest stored word w[idx+Nk-1] feeds the generator.
   always_comb begin
      temp_src = win[0];
      for (int j = 0; j < WIN_W; j++)
         if (3'(j) == nk_m1) temp_src = win[j];
   end

   assign rot      = (cnt == 3'd0);
   assign sub_only = (nk_m1 == 3'd7) && (cnt == 3'd4);
   assign sb_in    = rot ? {temp_src[23:0], temp_src[31:24]} : temp_src;

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (.a(sb_in[8*b +: 8]), .s(sb_out[8*b +: 8]));
   end

   always_comb begin
      if (rot)           temp = sb_out ^ {rcon, 24'h0};
      else if (sub_only) temp = sb_out;
      else               temp = temp_src;
   end

   assign gen_word = win[0] ^ temp;

   always_comb begin
      for (int j = 0; j < WIN_W; j++) begin
         if (3'(j) == nk_m1)     win_n[j] = gen_word;
         else if (3'(j) < nk_m1) win_n[j] = win[(j + 1) % WIN_W];
         else                    win_n[j] = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // NOTE: every path assigns defaults first so no latch can be inferred.
   always_comb begin
      state_n = state;
      if (bus.start)             state_n = legal ? RUN : IDLE;
      else if (xfer && rk_last)  state_n = IDLE;
      rk_valid = (state == RUN);
      busy     = (state == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the key window is a small register file and is cleared so no old key survives reset.
         for (int j = 0; j < WIN_W; j++) win[j] <= '0;
         nk_m1    <= 3'd3;
         last_idx <= 6'h3f;
         cnt      <= '0;
         idx      <= '0;
         rcon     <= 8'h01;
         key_err  <= 1'b0;
      end else begin
         key_err <= bus.start & ~legal;
         if (bus.start) begin
            cnt  <= '0;
            idx  <= '0;
            rcon <= 8'h01;
            if (legal) begin
               nk_m1    <= nk_m1_new;
               last_idx <= last_new;
               for (int j = 0; j < WIN_W; j++)
                  win[j] <= (3'(j) <= nk_m1_new) ? bus.key[255 - 32*j -: 32] : 32'h0;
            end else begin
               // last_idx parked out of range keeps rk_last low until the next legal load.
               last_idx <= 6'h3f;
               for (int j = 0; j < WIN_W; j++) win[j] <= '0;
            end
         end else if (xfer && !rk_last) begin
            for (int j = 0; j < WIN_W; j++) win[j] <= win_n[j];
            idx <= idx + 6'd1;
            cnt <= (cnt == nk_m1) ? 3'd0 : cnt + 3'd1;
            if (rot) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         end
      end
   end

   assign bus.rk_valid = rk_valid;
   assign bus.busy     = busy;
   assign bus.rk_word  = win[0];
   assign bus.rk_idx   = idx;
   assign bus.rk_round = idx[5:2];
   assign bus.rk_last  = rk_last;
   assign bus.key_err  = key_err;
endmodule

// File: tb/tb_aes_key_schedule_otf_multi.sv
// Directed bench for the on-the-fly AES key schedule using FIPS-197 expansion vectors.
// Covers all three key sizes, backpressure, abort/restart, illegal lengths and async reset.
module tb_aes_key_schedule_otf_multi;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   aes_key_schedule_otf_multi_if bus ();
   aes_key_schedule_otf_multi_if bus2 ();

   aes_key_schedule_otf_multi u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   aes_key_schedule_otf_multi #(.SUPPORT_192(1'b1), .SUPPORT_256(1'b0)) u_dut_n256 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [1:0] len, input logic [255:0] k);
      bus.start   = 1'b1;
      bus.key_len = len;
      bus.key     = k;
      step();
      bus.start   = 1'b0;
   endtask

   // Known words from the FIPS-197 key expansion examples.
   function automatic bit lookup(input int mode, input int i, output logic [31:0] w);
      w = '0;
      lookup = 1'b1;
      case (mode)
         0: case (i)
               0: w = 32'h2b7e1516;  1: w = 32'h28aed2a6;  2: w = 32'habf71588;
               3: w = 32'h09cf4f3c;  4: w = 32'ha0fafe17;  5: w = 32'h88542cb1;
               6: w = 32'h23a33939;  7: w = 32'h2a6c7605;  8: w = 32'hf2c295f2;
               9: w = 32'h7a96b943; 10: w = 32'h5935807a; 11: w = 32'h7359f67f;
              40: w = 32'hd014f9a8; 41: w = 32'hc9ee2589; 42: w = 32'he13f0cc8;
              43: w = 32'hb6630ca6;
              default: lookup = 1'b0;
            endcase
         1: case (i)
               0: w = 32'h8e73b0f7;  1: w = 32'hda0e6452;  2: w = 32'hc810f32b;
               3: w = 32'h809079e5;  4: w = 32'h62f8ead2;  5: w = 32'h522c6b7b;
               6: w = 32'hfe0c91f7; 51: w = 32'h01002202;
              default: lookup = 1'b0;
            endcase
         default: case (i)
               0: w = 32'h603deb10;  1: w = 32'h15ca71be;  2: w = 32'h2b73aef0;
               3: w = 32'h857d7781;  4: w = 32'h1f352c07;  5: w = 32'h3b6108d7;
               6: w = 32'h2d9810a3;  7: w = 32'h0914dff4;  8: w = 32'h9ba35411;
              12: w = 32'ha8b09c1a; 59: w = 32'h706c631e;
              default: lookup = 1'b0;
            endcase
      endcase
   endfunction

   // Drains a loaded schedule, optionally stalling 5 cycles at stall_idx and toggling ready.
   task automatic run_stream(input string tag, input int mode, input int last_idx,
                             input bit rnd, input int stall_idx);
      int          exp_idx = 0;
      int          cyc     = 0;
      int          idles   = 0;
      int          stalls  = 0;
      logic [31:0] w;
      while (bus.rk_valid && cyc < 300) begin
         check({tag, " idx"},   32'(bus.rk_idx),   32'(exp_idx));
         check({tag, " last"},  32'(bus.rk_last),  32'(exp_idx == last_idx));
         check({tag, " round"}, 32'(bus.rk_round), 32'(exp_idx >> 2));
         if (lookup(mode, exp_idx, w)) check($sformatf("%s w%0d", tag, exp_idx), bus.rk_word, w);
         if (exp_idx == stall_idx && stalls < 5) begin
            bus.rk_ready = 1'b0;
            stalls++;
         end else if (rnd) begin
            bus.rk_ready = ($urandom_range(0, 3) != 0);
         end else begin
            bus.rk_ready = 1'b1;
         end
         step();
         if (bus.rk_ready) exp_idx++;
         else              idles++;
         cyc++;
      end
      check({tag, " ended"},  32'(cyc < 300),  32'd1);
      check({tag, " count"},  32'(exp_idx),    32'(last_idx + 1));
      check({tag, " cycles"}, 32'(cyc),        32'(exp_idx + idles));
      check({tag, " busy"},   32'(bus.busy),   32'd0);
      check({tag, " hold"},   32'(bus.rk_idx), 32'(last_idx));
      bus.rk_ready = 1'b1;
   endtask

   initial begin
      int n;
      bus.start  = 1'b0; bus.key_len  = 2'b00; bus.key  = '0; bus.rk_ready  = 1'b0;
      bus2.start = 1'b0; bus2.key_len = 2'b00; bus2.key = '0; bus2.rk_ready = 1'b1;
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst valid", 32'(bus.rk_valid), 32'd0);
      check("rst busy",  32'(bus.busy),     32'd0);
      check("rst word",  bus.rk_word,       32'd0);
      check("rst idx",   32'(bus.rk_idx),   32'd0);
      check("rst last",  32'(bus.rk_last),  32'd0);
      check("rst err",   32'(bus.key_err),  32'd0);
      rst_n = 1'b1;
      step();

      // AES-128 without backpressure: 44 words in 44 cycles.
      bus.rk_ready = 1'b1;
      do_start(2'b00, K128);
      check("128 valid", 32'(bus.rk_valid), 32'd1);
      run_stream("128", 0, 43, 1'b0, -1);
      check("128 held word", bus.rk_word, 32'hb6630ca6);
      check("128 round",     32'(bus.rk_round), 32'd10);

      // AES-192.
      do_start(2'b01, K192);
      run_stream("192", 1, 51, 1'b0, -1);
      check("192 round", 32'(bus.rk_round), 32'd12);

      // AES-128 with 5-cycle stall at w7 and random ready.
      do_start(2'b00, K128);
      run_stream("128bp", 0, 43, 1'b1, 7);

      // Abort an AES-128 run at idx 20 with an AES-256 start coinciding with a transfer.
      do_start(2'b00, K128);
      n = 0;
      while (bus.rk_idx != 6'd20 && n < 100) begin step(); n++; end
      check("abort reach", 32'(bus.rk_idx), 32'd20);
      bus.start = 1'b1; bus.key_len = 2'b10; bus.key = K256;
      step();
      bus.start = 1'b0;
      check("abort idx",   32'(bus.rk_idx),   32'd0);
      check("abort word",  bus.rk_word,       32'h603deb10);
      check("abort valid", 32'(bus.rk_valid), 32'd1);
      run_stream("256", 2, 59, 1'b0, -1);

      // Illegal key length while running.
      do_start(2'b00, K128);
      step(); step();
      bus.start = 1'b1; bus.key_len = 2'b11;
      step();
      bus.start = 1'b0;
      check("err pulse", 32'(bus.key_err),  32'd1);
      check("err valid", 32'(bus.rk_valid), 32'd0);
      check("err busy",  32'(bus.busy),     32'd0);
      step();
      check("err clear", 32'(bus.key_err),  32'd0);
      check("err idle",  32'(bus.rk_valid), 32'd0);

      // AES-256 rejected when unsupported; AES-128 still accepted.
      bus2.start = 1'b1; bus2.key_len = 2'b10; bus2.key = K256;
      step();
      bus2.start = 1'b0;
      check("n256 err",   32'(bus2.key_err),  32'd1);
      check("n256 valid", 32'(bus2.rk_valid), 32'd0);
      step();
      check("n256 clear", 32'(bus2.key_err),  32'd0);
      bus2.start = 1'b1; bus2.key_len = 2'b00; bus2.key = K128;
      step();
      bus2.start = 1'b0;
      check("n256 128 valid", 32'(bus2.rk_valid), 32'd1);
      check("n256 128 w0",    bus2.rk_word,       32'h2b7e1516);
      check("n256 128 w1",    32'(bus2.key_err),  32'd0);

      // Asynchronous reset mid-run.
      do_start(2'b00, K128);
      step(); step(); step();
      #3 rst_n = 1'b0;
      #1;
      check("arst valid", 32'(bus.rk_valid), 32'd0);
      check("arst busy",  32'(bus.busy),     32'd0);
      check("arst word",  bus.rk_word,       32'd0);
      check("arst idx",   32'(bus.rk_idx),   32'd0);
      check("arst round", 32'(bus.rk_round), 32'd0);
      check("arst last",  32'(bus.rk_last),  32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step();
      check("arst no resume", 32'(bus.rk_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
